// File: rtl/contador_bcd_ud.sv
// contador_bcd_ud: two-digit packed-BCD up/down counter advanced by a slow tick.
// The tick is sampled as data through a synchroniser and turned into a one-cycle
// step strobe, so everything runs on clock_in. Drives two 7-segment digits.
module contador_bcd_ud #(
  parameter logic [7:0] MAX_COUNT      = 8'h99,
  parameter bit         WRAP           = 1'b1,
  parameter bit         SEG_ACTIVE_LOW = 1'b1
) (
  input  logic       clock_in,
  input  logic       reset_n,
  input  logic       tick_in,
  input  logic       enable,
  input  logic       up_down,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic [7:0] count_bcd,
  output logic [6:0] seg_units,
  output logic [6:0] seg_tens,
  output logic       tc,
  output logic       running
);

  typedef enum logic [1:0] {
    ST_HOLD  = 2'd0,
    ST_COUNT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // True when both nibbles of a packed value are decimal digits.
  function automatic logic bcd_valid(input logic [7:0] v);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
  endfunction

  // BCD +1; callers guarantee v is below the terminal value, so tens never exceeds 9.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [7:0] r;
    if (v[3:0] == 4'd9) begin
      r = {v[7:4] + 4'd1, 4'd0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

  // BCD -1; callers guarantee v is above zero.
  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    logic [7:0] r;
    if (v[3:0] == 4'd0) begin
      r = {v[7:4] - 4'd1, 4'd9};
    end else begin
      r = {v[7:4], v[3:0] - 4'd1};
    end
    return r;
  endfunction

  // Active-high {g,f,e,d,c,b,a} pattern; anything that is not a digit is blank.
  function automatic logic [6:0] seg_pattern(input logic [3:0] d);
    logic [6:0] p;
    case (d)
      4'd0:    p = 7'h3F;
      4'd1:    p = 7'h06;
      4'd2:    p = 7'h5B;
      4'd3:    p = 7'h4F;
      4'd4:    p = 7'h66;
      4'd5:    p = 7'h6D;
      4'd6:    p = 7'h7D;
      4'd7:    p = 7'h07;
      4'd8:    p = 7'h7F;
      4'd9:    p = 7'h6F;
      default: p = 7'h00;
    endcase
    return p;
  endfunction

  logic       sync1_r;
  logic       sync2_r;
  logic       sync3_r;
  logic       step_s;
  state_t     state_r;
  state_t     state_next_s;
  logic [7:0] count_r;
  logic [7:0] count_next_s;
  logic       tc_r;
  logic       tc_next_s;
  logic       running_r;
  logic       up_down_prev_r;
  logic       load_ok_s;
  logic       at_term_s;
  logic       do_step_s;

  // Two-stage synchroniser on the tick plus one stage of history for edge detection.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      sync3_r <= 1'b0;
    end else begin
      sync1_r <= tick_in;
      sync2_r <= sync1_r;
      sync3_r <= sync2_r;
    end
  end

  // Rising edge only: a tick held high yields a single step.
  assign step_s    = sync2_r & ~sync3_r;
  assign load_ok_s = load && bcd_valid(load_val) && (load_val <= MAX_COUNT);
  assign at_term_s = up_down ? (count_r == MAX_COUNT) : (count_r == 8'h00);
  assign do_step_s = (state_r == ST_COUNT) && enable && step_s;

  // Next count, terminal pulse and FSM state; load outranks a coincident step.
  always_comb begin
    count_next_s = count_r;
    tc_next_s    = 1'b0;
    state_next_s = state_r;
    if (load_ok_s) begin
      count_next_s = load_val;
    end else if (do_step_s) begin
      if (at_term_s) begin
        tc_next_s = 1'b1;
        if (WRAP) begin
          count_next_s = up_down ? 8'h00 : MAX_COUNT;
        end else begin
          count_next_s = count_r;
        end
      end else begin
        count_next_s = up_down ? bcd_inc(count_r) : bcd_dec(count_r);
      end
    end else begin
      count_next_s = count_r;
    end

    case (state_r)
      ST_HOLD: begin
        if (enable) begin
          state_next_s = ST_COUNT;
        end else begin
          state_next_s = ST_HOLD;
        end
      end
      ST_COUNT: begin
        if (!enable) begin
          state_next_s = ST_HOLD;
        end else if (!load_ok_s && do_step_s && at_term_s && !WRAP) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_COUNT;
        end
      end
      ST_DONE: begin
        if (!enable) begin
          state_next_s = ST_HOLD;
        end else if (load_ok_s || (up_down != up_down_prev_r)) begin
          state_next_s = ST_COUNT;
        end else begin
          state_next_s = ST_DONE;
        end
      end
      default: begin
        state_next_s = ST_HOLD;
      end
    endcase
  end

  // FSM state, count and registered status outputs.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      state_r        <= ST_HOLD;
      count_r        <= 8'h00;
      tc_r           <= 1'b0;
      running_r      <= 1'b0;
      up_down_prev_r <= 1'b0;
    end else begin
      state_r        <= state_next_s;
      count_r        <= count_next_s;
      tc_r           <= tc_next_s;
      running_r      <= (state_next_s == ST_COUNT);
      up_down_prev_r <= up_down;
    end
  end

  assign count_bcd = count_r;
  assign tc        = tc_r;
  assign running   = running_r;

  // Segment decode straight from the registered count, polarity-adjusted.
  always_comb begin
    seg_units = seg_pattern(count_r[3:0]) ^ {7{SEG_ACTIVE_LOW}};
    seg_tens  = seg_pattern(count_r[7:4]) ^ {7{SEG_ACTIVE_LOW}};
  end

endmodule

// File: tb/tb_contador_bcd_ud.sv
// Bench for contador_bcd_ud: one wrapping and one stopping instance share stimulus;
// a decimal reference model predicts each cycle into queues checked by a monitor.
module tb_contador_bcd_ud;

  logic       clock_in = 1'b0;
  logic       reset_n;
  logic       tick_in;
  logic       enable;
  logic       up_down;
  logic       load;
  logic [7:0] load_val;

  logic [7:0] count_w, count_s;
  logic [6:0] su_w, st_w, su_s, st_s;
  logic       tc_w, tc_s, run_w, run_s;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock_in = ~clock_in;

  contador_bcd_ud #(.MAX_COUNT(8'h99), .WRAP(1'b1), .SEG_ACTIVE_LOW(1'b1)) dut_w (
    .clock_in(clock_in), .reset_n(reset_n), .tick_in(tick_in), .enable(enable),
    .up_down(up_down), .load(load), .load_val(load_val), .count_bcd(count_w),
    .seg_units(su_w), .seg_tens(st_w), .tc(tc_w), .running(run_w));

  contador_bcd_ud #(.MAX_COUNT(8'h99), .WRAP(1'b0), .SEG_ACTIVE_LOW(1'b1)) dut_s (
    .clock_in(clock_in), .reset_n(reset_n), .tick_in(tick_in), .enable(enable),
    .up_down(up_down), .load(load), .load_val(load_val), .count_bcd(count_s),
    .seg_units(su_s), .seg_tens(st_s), .tc(tc_s), .running(run_s));

  // mode: 0 = hold, 1 = counting, 2 = stopped at terminal
  typedef struct {
    int cnt;
    int mode;
    bit tc;
    bit run;
    bit pud;
    bit seen1, seen2, seen3;
  } model_t;

  typedef struct {
    int cnt;
    bit tc;
    bit run;
  } exp_t;

  model_t mdl_w, mdl_s;
  exp_t   q_w[$];
  exp_t   q_s[$];

  function automatic logic [7:0] to_bcd(input int v);
    logic [7:0] r;
    r[7:4] = 4'(v / 10);
    r[3:0] = 4'(v % 10);
    return r;
  endfunction

  // Common-anode glyphs {g,f,e,d,c,b,a}: a zero bit lights a segment.
  function automatic logic [6:0] seg_exp(input int d);
    logic [6:0] on;
    case (d)
      0: on = 7'b0111111;  1: on = 7'b0000110;  2: on = 7'b1011011;
      3: on = 7'b1001111;  4: on = 7'b1100110;  5: on = 7'b1101101;
      6: on = 7'b1111101;  7: on = 7'b0000111;  8: on = 7'b1111111;
      9: on = 7'b1101111;  default: on = 7'b0000000;
    endcase
    return ~on;
  endfunction

  function automatic model_t reset_model();
    model_t m;
    m.cnt = 0; m.mode = 0; m.tc = 1'b0; m.run = 1'b0; m.pud = 1'b0;
    m.seen1 = 1'b0; m.seen2 = 1'b0; m.seen3 = 1'b0;
    return m;
  endfunction

  // One clock edge of the specified behaviour, counting in plain decimal 0..99.
  function automatic model_t model_next(input model_t s, input bit wrap, input bit en,
                                        input bit ud, input bit ld, input logic [7:0] lv,
                                        input bit tk);
    model_t n;
    int lt, lu;
    bit ldok, step, term;
    n = s;
    lt = int'(lv[7:4]);
    lu = int'(lv[3:0]);
    ldok = ld && (lt <= 9) && (lu <= 9);
    // tick rose between the samples taken 3 and 2 edges back -> this is the 3rd edge
    step = s.seen2 && !s.seen3;
    term = ud ? (s.cnt == 99) : (s.cnt == 0);
    n.tc = 1'b0;
    if (ldok) begin
      n.cnt = lt * 10 + lu;
    end else if (s.mode == 1 && en && step) begin
      if (term) begin
        n.tc = 1'b1;
        if (wrap) n.cnt = ud ? 0 : 99;
      end else begin
        n.cnt = ud ? s.cnt + 1 : s.cnt - 1;
      end
    end
    if (s.mode == 0) begin
      n.mode = en ? 1 : 0;
    end else if (s.mode == 1) begin
      if (!en) n.mode = 0;
      else if (!ldok && step && term && !wrap) n.mode = 2;
      else n.mode = 1;
    end else begin
      if (!en) n.mode = 0;
      else if (ldok || (ud != s.pud)) n.mode = 1;
      else n.mode = 2;
    end
    n.run = (n.mode == 1);
    n.pud = ud;
    n.seen3 = s.seen2;
    n.seen2 = s.seen1;
    n.seen1 = tk;
    return n;
  endfunction

  function automatic exp_t to_exp(input model_t m);
    exp_t e;
    e.cnt = m.cnt; e.tc = m.tc; e.run = m.run;
    return e;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: predicts every edge and queues the expectation.
  always @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      mdl_w = reset_model();
      mdl_s = reset_model();
      q_w.delete();
      q_s.delete();
    end else begin
      mdl_w = model_next(mdl_w, 1'b1, enable, up_down, load, load_val, tick_in);
      mdl_s = model_next(mdl_s, 1'b0, enable, up_down, load, load_val, tick_in);
      q_w.push_back(to_exp(mdl_w));
      q_s.push_back(to_exp(mdl_s));
    end
  end

  // Monitor: compare DUT outputs with queued expectations mid-cycle.
  always @(negedge clock_in) begin
    exp_t e;
    if (reset_n === 1'b1) begin
      if (q_w.size() > 0) begin
        e = q_w.pop_front();
        chk("wrap count", int'(count_w), int'(to_bcd(e.cnt)));
        chk("wrap seg_units", int'(su_w), int'(seg_exp(e.cnt % 10)));
        chk("wrap seg_tens", int'(st_w), int'(seg_exp(e.cnt / 10)));
        chk("wrap tc", int'(tc_w), int'(e.tc));
        chk("wrap running", int'(run_w), int'(e.run));
      end
      if (q_s.size() > 0) begin
        e = q_s.pop_front();
        chk("stop count", int'(count_s), int'(to_bcd(e.cnt)));
        chk("stop seg_units", int'(su_s), int'(seg_exp(e.cnt % 10)));
        chk("stop seg_tens", int'(st_s), int'(seg_exp(e.cnt / 10)));
        chk("stop tc", int'(tc_s), int'(e.tc));
        chk("stop running", int'(run_s), int'(e.run));
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clock_in);
  endtask

  task automatic tick(input int hi, input int lo);
    tick_in = 1'b1;
    cycles(hi);
    tick_in = 1'b0;
    cycles(lo);
  endtask

  task automatic do_load(input logic [7:0] v);
    load_val = v;
    load = 1'b1;
    cycles(1);
    load = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; tick_in = 1'b0; enable = 1'b0; up_down = 1'b1;
    load = 1'b0; load_val = 8'h00;
    cycles(3);
    reset_n = 1'b1;
    cycles(2);

    // asynchronous reset in the middle of a run at 37
    do_load(8'h35);
    enable = 1'b1;
    cycles(2);
    tick(2, 3);
    tick(2, 3);
    chk("pre-reset count", int'(count_w), 32'h37);
    #2 reset_n = 1'b0;
    #1;
    chk("reset count", int'(count_w), 32'h00);
    chk("reset count stop", int'(count_s), 32'h00);
    chk("reset seg_units", int'(su_w), 32'h40);
    chk("reset seg_tens", int'(st_w), 32'h40);
    chk("reset tc", int'(tc_w), 0);
    chk("reset running", int'(run_w), 0);
    cycles(2);
    reset_n = 1'b1;
    cycles(1);

    // 12 up steps from 08, crossing the 09 -> 10 carry
    do_load(8'h08);
    cycles(2);
    repeat (12) tick(2, 3);
    chk("up run end", int'(count_w), 32'h20);
    chk("up run end stop", int'(count_s), 32'h20);

    // terminal going up: wrap vs stop
    do_load(8'h99);
    cycles(2);
    tick(2, 4);
    chk("wrap at 99", int'(count_w), 32'h00);
    chk("stop at 99", int'(count_s), 32'h99);
    chk("stop running", int'(run_s), 0);
    tick(2, 4);
    tick(2, 4);
    chk("stop frozen", int'(count_s), 32'h99);
    // turn around: wrapper goes 02->01->00->99, stopper resumes 99->96
    up_down = 1'b0;
    cycles(2);
    repeat (3) tick(2, 4);
    chk("wrap down at 00", int'(count_w), 32'h99);
    chk("stop resumed down", int'(count_s), 32'h96);

    // load coincident with a step wins, invalid loads ignored
    do_load(8'h50);
    cycles(2);
    tick_in = 1'b1;
    cycles(2);
    load_val = 8'h42;
    load = 1'b1;
    cycles(1);
    load = 1'b0;
    tick_in = 1'b0;
    cycles(4);
    chk("load beats step", int'(count_w), 32'h42);
    do_load(8'h4A);
    do_load(8'hA0);
    cycles(2);
    chk("invalid load ignored", int'(count_w), 32'h42);
    chk("invalid load ignored stop", int'(count_s), 32'h42);

    // disabled: ticks do nothing
    enable = 1'b0;
    cycles(2);
    repeat (3) tick(2, 3);
    chk("disabled frozen", int'(count_w), 32'h42);
    chk("disabled running", int'(run_w), 0);
    enable = 1'b1;
    cycles(2);
    // glitch between edges: never sampled
    #2 tick_in = 1'b1;
    #2 tick_in = 1'b0;
    cycles(5);
    chk("short glitch", int'(count_w), 32'h42);
    // glitch straddling an edge: at most one step
    #3 tick_in = 1'b1;
    #4 tick_in = 1'b0;
    cycles(5);
    chk("straddling glitch", int'(count_w), 32'h41);
    // long high level: exactly one step
    tick(12, 5);
    chk("held tick", int'(count_w), 32'h40);

    // randomized traffic, checked by the scoreboard
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 19) == 0) enable = ~enable;
      if ($urandom_range(0, 11) == 0) up_down = ~up_down;
      if ($urandom_range(0, 2) == 0) tick_in = ~tick_in;
      if ($urandom_range(0, 24) == 0) begin
        load = 1'b1;
        if ($urandom_range(0, 1) == 0) load_val = 8'($urandom_range(0, 255));
        else load_val = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      end else begin
        load = 1'b0;
      end
      cycles(1);
    end
    load = 1'b0;
    cycles(3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
